fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and instruction-register stage that sits directly downstream of the SISC control FSM.
- It consumes pc_rst, pc_write, pc_sel, br_sel and ir_load from the FSM.
- It runs an instruction-memory request/acknowledge fetch sequence and holds the current instruction.
- It returns the opcode and mm fields to the FSM, plus a busy flag so the FSM can stall.

Parameters:
PC_W, 16, program counter width in bits; word-addressed.
INSTR_W, 32, instruction width in bits.
RESET_PC, 0, PC value after reset or pc_rst.
TIMEOUT, 15, maximum WAIT cycles before fetch_err (only with FETCH_TIMEOUT_EN).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
pc_rst  in  1  synchronous PC reload to RESET_PC; aborts any fetch in progress.
pc_write  in  1  PC update enable.
pc_sel  in  1  0 = sequential (pc+1); 1 = branch target.
br_sel  in  1  branch mode: 0 = relative (pc+1+simm); 1 = absolute (imm).
ir_load  in  1  start a fetch at the current PC.
imem_req  out  1  fetch request; held high until acknowledged.
imem_addr  out  PC_W  fetch address; registered and stable while imem_req is high.
imem_ack  in  1  memory acknowledge; imem_rdata is valid in the same cycle.
imem_rdata  in  INSTR_W  instruction word from memory.
pc  out  PC_W  current PC.
instr  out  INSTR_W  instruction register contents.
opcode  out  4  instr[31:28].
mm  out  4  instr[27:24].
imm  out  16  instr[15:0].
fetch_busy  out  1  high while a fetch is outstanding.
fetch_err  out  1  sticky timeout flag; tied to 0 when the optional feature is absent.

Behaviour:
- Reset values (rst high, asynchronous): pc = RESET_PC, instr = 0 (NOOP), imem_req = 0, imem_addr = 0, fetch_busy = 0, fetch_err = 0, state = IDLE, timeout counter = 0.
- PC update priority, evaluated each clock: pc_rst, then pc_write, then hold.
  - pc_write with pc_sel = 0: pc <= pc + 1, modulo 2^PC_W.
  - pc_write with pc_sel = 1, br_sel = 0: pc <= pc + 1 + sign-extended imm, truncated to PC_W bits; wraps.
  - pc_write with pc_sel = 1, br_sel = 1: pc <= imm[PC_W-1:0], zero-extended if PC_W > 16.
  - pc_write is accepted in every fetch state; it never affects the address of a fetch already launched.
- Fetch FSM, states IDLE and WAIT:
  - IDLE, ir_load = 1, pc_rst = 0: imem_addr <= pc (value before any same-cycle pc_write), imem_req <= 1, fetch_busy <= 1, go to WAIT.
  - WAIT, imem_ack = 1: instr <= imem_rdata, imem_req <= 0, fetch_busy <= 0, go to IDLE.
  - WAIT, imem_ack = 0: hold all outputs.
- Latency: with ir_load in cycle N, imem_req rises at N+1. Earliest ack is in N+1, which makes instr valid from N+2. Each wait cycle adds one cycle.
- ir_load while in WAIT: ignored; no queueing.
- imem_ack while in IDLE: ignored; instr unchanged.
- pc_rst while in WAIT: abort the fetch. Next cycle: IDLE, imem_req = 0, fetch_busy = 0, instr unchanged. A late ack is ignored.
- pc_rst and ir_load in the same cycle: pc_rst wins; no fetch starts.
- imem_ack and pc_rst in the same cycle while in WAIT: abort wins; instr unchanged.
- rst asserted mid-fetch: all outputs go to their reset values immediately.
- opcode, mm and imm are decoded combinationally from instr only, never from imem_rdata.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT: fetch_err <= 1 (sticky until rst or pc_rst), instr <= 0 (NOOP), imem_req <= 0, state goes to IDLE.
  - An ack arriving in the same cycle as the counter reaching TIMEOUT wins: normal load, no error.
- When undefined: no counter logic; fetch_err is tied to 0; WAIT holds indefinitely.

Test Plan:
- Reset then ir_load with zero-wait ack, rdata = 0x8100_0003 -> imem_addr = 0x0000; instr = 0x8100_0003 two cycles after ir_load; opcode = 8; mm = 1; pc stays 0x0000.
- pc = 0x0010, pc_write with pc_sel = 1, br_sel = 0, imm = 0xFFFC -> pc = 0x000D. Repeat with br_sel = 1, imm = 0x0042 -> pc = 0x0042.
- pc = 0xFFFF, pc_write with pc_sel = 0 -> pc = 0x0000 (wrap).
- ir_load with ack delayed 3 cycles -> imem_req and fetch_busy high for 3 cycles, imem_addr stable; a second ir_load during WAIT has no effect.
- pc_rst asserted during WAIT, then ack 2 cycles later -> imem_req drops next cycle; instr unchanged; pc = RESET_PC.
- With FETCH_TIMEOUT_EN, TIMEOUT = 4, no ack -> fetch_err = 1 after 4 WAIT cycles; instr = 0; fetch_err cleared by pc_rst.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC and instruction register with a request/acknowledge instruction fetch.
// Optional FETCH_TIMEOUT_EN: bounds each fetch to TIMEOUT wait cycles and flags fetch_err.
module fetch_unit #(
    parameter int PC_W     = 16,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [15:0]        imm,
    output logic               fetch_busy,
    output logic               fetch_err
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic            state;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] simm_pc;
    logic [PC_W-1:0] abs_pc;

    assign opcode = instr[31:28];
    assign mm     = instr[27:24];
    assign imm    = instr[15:0];

    // Sign-extend (or truncate) the immediate for relative branches; zero-extend for absolute.
    assign simm_pc = PC_W'($signed(imm));
    assign abs_pc  = PC_W'(imm);

    always_comb begin
        next_pc = pc + PC_W'(1);
        if (pc_sel) begin
            if (br_sel)
                next_pc = abs_pc;
            else
                next_pc = pc + PC_W'(1) + simm_pc;
        end
    end

    assign fetch_busy = imem_req;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    assign fetch_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign fetch_err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= PC_W'(RESET_PC);
            instr     <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            state     <= ST_IDLE;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            if (pc_rst)
                pc <= PC_W'(RESET_PC);
            else if (pc_write)
                pc <= next_pc;

            if (pc_rst) begin
                state    <= ST_IDLE;
                imem_req <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt <= '0;
                err_q    <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ir_load) begin
                            // Launch address is the PC before any same-cycle pc_write.
                            imem_addr <= pc;
                            imem_req  <= 1'b1;
                            state     <= ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
                            wait_cnt  <= '0;
`endif
                        end
                    end
                    default: begin
                        if (imem_ack) begin
                            instr    <= imem_rdata;
                            imem_req <= 1'b0;
                            state    <= ST_IDLE;
                        end
`ifdef FETCH_TIMEOUT_EN
                        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                            err_q    <= 1'b1;
                            instr    <= '0;
                            imem_req <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, pc, imm;
    logic [31:0] imem_rdata, instr;
    logic [3:0]  opcode, mm;
    logic        fetch_busy, fetch_err;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.PC_W(16), .INSTR_W(32), .RESET_PC(0), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .opcode(opcode),
        .mm(mm), .imm(imm), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch; optionally issues a sequential pc_write in the launch cycle.
    task automatic fetch0(input string tag, input logic [15:0] addr_exp,
                          input logic [31:0] data, input logic pw);
        ir_load = 1'b1; pc_write = pw; pc_sel = 1'b0;
        tick();
        ir_load = 1'b0; pc_write = 1'b0;
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, {16'd0, imem_addr}, {16'd0, addr_exp});
        imem_ack = 1'b1; imem_rdata = data;
        tick();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        check({tag, "_instr"}, instr, data);
        check({tag, "_idle"}, {31'd0, imem_req}, 32'd0);
    endtask

    task automatic pc_update(input logic sel, input logic br);
        pc_write = 1'b1; pc_sel = sel; br_sel = br;
        tick();
        pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
        ir_load = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        check("rst_pc", {16'd0, pc}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", {16'd0, imem_addr}, 32'h0);
        check("rst_busy", {31'd0, fetch_busy}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait fetch at pc 0
        fetch0("f0", 16'h0000, 32'h8100_0003, 1'b0);
        check("f0_opcode", {28'd0, opcode}, 32'd8);
        check("f0_mm", {28'd0, mm}, 32'd1);
        check("f0_pc", {16'd0, pc}, 32'h0000);

        for (int i = 0; i < 16; i++) pc_update(1'b0, 1'b0);
        check("seq16_pc", {16'd0, pc}, 32'h0010);

        fetch0("f1", 16'h0010, 32'h1000_FFFC, 1'b0);
        check("f1_imm", {16'd0, imm}, 32'h0000_FFFC);
        pc_update(1'b1, 1'b0);
        check("br_rel_pc", {16'd0, pc}, 32'h000D);

        // pc_write in the launch cycle must not disturb the launched address
        fetch0("f2", 16'h000D, 32'h2000_0042, 1'b1);
        check("f2_pc", {16'd0, pc}, 32'h000E);
        pc_update(1'b1, 1'b1);
        check("br_abs_pc", {16'd0, pc}, 32'h0042);

        fetch0("f3", 16'h0042, 32'h3000_FFFF, 1'b0);
        pc_update(1'b1, 1'b1);
        check("abs_ffff_pc", {16'd0, pc}, 32'hFFFF);
        pc_update(1'b0, 1'b0);
        check("wrap_pc", {16'd0, pc}, 32'h0000);
        pc_update(1'b0, 1'b0);

        // Three wait cycles, with a second ir_load during WAIT
        ir_load = 1'b1;
        tick();
        check("w_req1", {31'd0, imem_req}, 32'd1);
        check("w_busy1", {31'd0, fetch_busy}, 32'd1);
        check("w_addr1", {16'd0, imem_addr}, 32'h0001);
        ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        tick();
        ir_load = 1'b0; pc_write = 1'b0;
        check("w_req2", {31'd0, imem_req}, 32'd1);
        check("w_addr2", {16'd0, imem_addr}, 32'h0001);
        check("w_pc2", {16'd0, pc}, 32'h0002);
        tick();
        check("w_req3", {31'd0, imem_req}, 32'd1);
        check("w_busy3", {31'd0, fetch_busy}, 32'd1);
        check("w_addr3", {16'd0, imem_addr}, 32'h0001);
        check("w_instr3", instr, 32'h3000_FFFF);
        imem_ack = 1'b1; imem_rdata = 32'h4500_ABCD;
        tick();
        imem_ack = 1'b0;
        check("w_instr", instr, 32'h4500_ABCD);
        check("w_opcode", {28'd0, opcode}, 32'd4);
        check("w_mm", {28'd0, mm}, 32'd5);
        check("w_req_done", {31'd0, imem_req}, 32'd0);
        tick();
        check("w_no_queue", {31'd0, imem_req}, 32'd0);

        // pc_rst aborts a fetch; late ack ignored
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        pc_rst = 1'b1;
        tick();
        pc_rst = 1'b0;
        check("ab_req", {31'd0, imem_req}, 32'd0);
        check("ab_busy", {31'd0, fetch_busy}, 32'd0);
        check("ab_pc", {16'd0, pc}, 32'h0000);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        tick();
        imem_ack = 1'b0;
        check("ab_late_ack", instr, 32'h4500_ABCD);

        // ack and pc_rst together in WAIT: abort wins
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        pc_rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        tick();
        pc_rst = 1'b0; imem_ack = 1'b0;
        check("ackrst_instr", instr, 32'h4500_ABCD);
        check("ackrst_req", {31'd0, imem_req}, 32'd0);

        // pc_rst and ir_load together: no fetch
        pc_rst = 1'b1; ir_load = 1'b1;
        tick();
        pc_rst = 1'b0; ir_load = 1'b0;
        check("rstld_req", {31'd0, imem_req}, 32'd0);

        // ack in IDLE ignored
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        imem_ack = 1'b0;
        check("idle_ack", instr, 32'h4500_ABCD);

        // Asynchronous rst mid-fetch
        pc_update(1'b0, 1'b0);
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_pc", {16'd0, pc}, 32'h0000);
        check("arst_instr", instr, 32'h0);
        check("arst_addr", {16'd0, imem_addr}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

`ifdef FETCH_TIMEOUT_EN
        ir_load = 1'b1;
        fetch0("pre_to", 16'h0000, 32'h9900_1234, 1'b0);
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        tick(); tick(); tick();
        check("to_req_last_wait", {31'd0, imem_req}, 32'd1);
        check("to_err_before", {31'd0, fetch_err}, 32'd0);
        tick();
        check("to_err", {31'd0, fetch_err}, 32'd1);
        check("to_instr", instr, 32'h0);
        check("to_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("to_sticky", {31'd0, fetch_err}, 32'd1);
        pc_rst = 1'b1;
        tick();
        pc_rst = 1'b0;
        check("to_clear", {31'd0, fetch_err}, 32'd0);
`else
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        repeat (6) tick();
        check("nto_req", {31'd0, imem_req}, 32'd1);
        check("nto_err", {31'd0, fetch_err}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hA100_0001;
        tick();
        imem_ack = 1'b0;
        check("nto_instr", instr, 32'hA100_0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
